// File: rtl/note_source_arbiter.sv
// Routes free/auto/learn note, LED and octave to a single output path with a mute gap on mode change.
// Define NOTE_ARTIC_EN to insert a short silence between consecutive distinct notes.
module note_source_arbiter #(
    parameter int GAP_CYCLES   = 1000000,
    parameter int ARTIC_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic [3:0] free_note,
    input  logic [6:0] free_led,
    input  logic [3:0] auto_note,
    input  logic [6:0] auto_led,
    input  logic [1:0] auto_octave,
    input  logic [3:0] learn_note,
    input  logic [6:0] learn_led,
    input  logic [1:0] octave_in,
    output logic [3:0] note_out,
    output logic [6:0] led_out,
    output logic [1:0] octave_out,
    output logic [2:0] grant,
    output logic       busy
);

    localparam int MAX_CYCLES =
        (GAP_CYCLES > ARTIC_CYCLES) ? GAP_CYCLES : ARTIC_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
`ifdef NOTE_ARTIC_EN
    localparam logic [CW-1:0] ARTIC_LAST = CW'(ARTIC_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        MUTE,
        PLAY,
        ARTIC
    } state_t;

    state_t        state;
    logic [2:0]    mode_q;
    logic [2:0]    target;
    logic [CW-1:0] cnt;

    logic          mode_ok;
    logic          retarget;
    logic [3:0]    src_note;
    logic [6:0]    src_led;
    logic [1:0]    src_octave;
`ifdef NOTE_ARTIC_EN
    logic          note_split;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= 3'b000;
        end else begin
            mode_q <= mode;
        end
    end

    always_comb begin
        mode_ok    = (mode_q == 3'b100) || (mode_q == 3'b010) ||
                     (mode_q == 3'b001);
        retarget   = (mode_q != target);
        src_note   = 4'd0;
        src_led    = 7'd0;
        src_octave = octave_in;
        case (target)
            3'b100: begin
                src_note = free_note;
                src_led  = free_led;
            end
            3'b010: begin
                src_note   = auto_note;
                src_led    = auto_led;
                src_octave = auto_octave;
            end
            3'b001: begin
                src_note = learn_note;
                src_led  = learn_led;
            end
            default: ;
        endcase
    end

`ifdef NOTE_ARTIC_EN
    // Only a direct jump between two sounding notes needs a gap.
    always_comb begin
        note_split = (note_out != 4'd0) && (src_note != 4'd0) &&
                     (src_note != note_out);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            target     <= 3'b000;
            cnt        <= '0;
            note_out   <= 4'd0;
            led_out    <= 7'd0;
            octave_out <= 2'b01;
            grant      <= 3'b000;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mode_ok) begin
                        state  <= MUTE;
                        target <= mode_q;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                MUTE: begin
                    if (!mode_ok) begin
                        state      <= IDLE;
                        target     <= 3'b000;
                        cnt        <= '0;
                        note_out   <= 4'd0;
                        led_out    <= 7'd0;
                        octave_out <= 2'b01;
                        grant      <= 3'b000;
                        busy       <= 1'b0;
                    end else if (retarget) begin
                        target <= mode_q;
                        cnt    <= '0;
                    end else if (cnt == GAP_LAST) begin
                        state      <= PLAY;
                        cnt        <= '0;
                        grant      <= target;
                        busy       <= 1'b0;
                        note_out   <= src_note;
                        led_out    <= src_led;
                        octave_out <= src_octave;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PLAY: begin
                    if (!mode_ok) begin
                        state      <= IDLE;
                        target     <= 3'b000;
                        cnt        <= '0;
                        note_out   <= 4'd0;
                        led_out    <= 7'd0;
                        octave_out <= 2'b01;
                        grant      <= 3'b000;
                        busy       <= 1'b0;
                    end else if (retarget) begin
                        state    <= MUTE;
                        target   <= mode_q;
                        cnt      <= '0;
                        note_out <= 4'd0;
                        led_out  <= 7'd0;
                        grant    <= 3'b000;
                        busy     <= 1'b1;
                    end else begin
                        led_out    <= src_led;
                        octave_out <= src_octave;
`ifdef NOTE_ARTIC_EN
                        if (note_split) begin
                            state    <= ARTIC;
                            cnt      <= '0;
                            note_out <= 4'd0;
                        end else begin
                            note_out <= src_note;
                        end
`else
                        note_out   <= src_note;
`endif
                    end
                end
`ifdef NOTE_ARTIC_EN
                ARTIC: begin
                    if (!mode_ok) begin
                        state      <= IDLE;
                        target     <= 3'b000;
                        cnt        <= '0;
                        note_out   <= 4'd0;
                        led_out    <= 7'd0;
                        octave_out <= 2'b01;
                        grant      <= 3'b000;
                        busy       <= 1'b0;
                    end else if (retarget) begin
                        state    <= MUTE;
                        target   <= mode_q;
                        cnt      <= '0;
                        note_out <= 4'd0;
                        led_out  <= 7'd0;
                        grant    <= 3'b000;
                        busy     <= 1'b1;
                    end else begin
                        // Later note changes here do not restart the silence.
                        led_out    <= src_led;
                        octave_out <= src_octave;
                        if (cnt == ARTIC_LAST) begin
                            state    <= PLAY;
                            cnt      <= '0;
                            note_out <= src_note;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
